mem_copy_master: RTL
====================

Name: mem_copy_master

Overview:
- Bus initiator that drives the 8-bit memory-system interface (address / we / data_in out, data_out back) to copy a block of bytes from a source range to a destination range.
- Address map is fixed: ROM 0x00-0x7F (read-only), RAM 0x80-0xDF, output ports 0xE0-0xE1, input ports 0xF0-0xF1 (read-only).
- Sits between a control source (test harness or future CPU) and the memory-system top.
- Performs one read-then-write per byte, in forward address order.

Parameters:
- RD_LAT, 1, clock edges from the end of the RD cycle until mem_rdata is captured; legal range 1-4.
- WR_LO, 8'h80, lowest writable address.
- WR_HI, 8'hE1, highest writable address.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request pulse; sampled only in IDLE.
- src_addr  input  8  first source address, latched on an accepted start.
- dst_addr  input  8  first destination address, latched on an accepted start.
- len  input  8  byte count, 1-255.
- abort  input  1  terminates the transfer early; sampled while busy.
- mem_rdata  input  8  read data from the memory system's data_out.
- mem_addr  output  8  address to the memory system (registered).
- mem_we  output  1  write enable (registered).
- mem_wdata  output  8  write data (registered).
- busy  output  1  high while a transfer is active.
- done  output  1  one-cycle completion pulse.
- err  output  1  request rejected; sticky until the next start.
- xfer_count  output  8  number of bytes written in the current or last transfer.

Behaviour:
- Reset (reset=0, async): state=IDLE. mem_addr=0, mem_we=0, mem_wdata=0, busy=0, done=0, err=0, xfer_count=0, internal counters=0. Bytes already written stay written. Operation resumes on the first rising edge after reset=1.
- All outputs are registered. done is low except for its one-cycle pulse.
- States: IDLE, RD, RD_WAIT, WR.
- IDLE, start=1 at edge e0:
  - Clear xfer_count.
  - Validate using 9-bit sums: len!=0; src+len-1 <= 0xFF; dst >= WR_LO; dst+len-1 <= WR_HI.
  - Invalid: stay IDLE; done=1 and err=1 in the cycle after e0; busy=0; mem_we is never asserted.
  - Valid: latch src, dst and len; err=0; busy=1; go to RD.
- RD (1 cycle): mem_addr=src+i, mem_we=0. Go to RD_WAIT.
- RD_WAIT (RD_LAT cycles): mem_addr held. On the last edge, capture mem_rdata into the byte buffer and go to WR.
- WR (1 cycle): mem_addr=dst+i, mem_wdata=buffer, mem_we=1. The memory commits the write at the edge ending this cycle. At that edge, i and xfer_count increment.
  - If i+1==len: go to IDLE with busy=0 and done=1 for one cycle.
  - Otherwise go to RD.
- mem_we is high only during WR cycles.
- Throughput: (2+RD_LAT) cycles per byte. With RD_LAT=1 and len=N, done is high in the cycle after edge e0+3N.
- Overlapping ranges: strict forward copy; byte i is read before byte i is written. When dst>src and the ranges overlap, the source pattern replicates forward. This is the defined behaviour.
- abort=1 sampled at any edge while busy: next state is IDLE, done=1, err=0.
  - If the current state is WR, that write completes and is counted.
  - No further mem_we is asserted.
  - A shortened transfer is indicated by xfer_count<len.
- start while busy is ignored. start and abort in the same IDLE cycle: start is processed and abort is ignored.
- Address arithmetic is 8-bit. Validation guarantees no wrap past 0xFF.

Test Plan:
- ROM bytes 0x10-0x13 preloaded A1,B2,C3,D4; start src=0x10, dst=0x80, len=4 -> four mem_we pulses to 0x80-0x83 with A1,B2,C3,D4; done at edge e0+12; xfer_count=4; err=0; RAM reads back A1,B2,C3,D4.
- RAM 0x90=0x5A, 0x91=0xC3; start src=0x90, dst=0xE0, len=2 -> port_out_00=0x5A, port_out_01=0xC3; done at e0+6.
- Rejects, checked one at a time: dst=0x7F len=1; dst=0xE1 len=2; src=0xFF len=2; len=0 -> each gives done=1 and err=1 in the cycle after start, busy=0, mem_we never high, xfer_count=0.
- src=0x00, dst=0x80, len=5; abort=1 during the RD_WAIT of byte 2 -> exactly 2 writes (0x80, 0x81); done next cycle; err=0; xfer_count=2. Repeat with abort raised during the WR of byte 2 -> 3 writes; xfer_count=3.
- Overlap: RAM 0x80=0x11, 0x81=0x22; src=0x80, dst=0x81, len=2 -> 0x81=0x11, 0x82=0x11.
- reset=0 asserted mid-WR of a len=8 copy -> all outputs drop to zero immediately, without waiting for a clock edge. start pulsed while busy in a separate run -> ignored, with no change to the latched src, dst or len.

Source files
------------

// File: rtl/mem_copy_master_if.sv
// Byte-wide memory-system bus: registered address/write strobe/write data out,
// read data back from the memory system's data_out.
interface mem_copy_master_if;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_copy_master.sv
// Block-copy bus initiator: one read then one write per byte, forward order,
// with request validation against the writable window and early abort.
module mem_copy_master #(
  parameter int         RD_LAT = 1,
  parameter logic [7:0] WR_LO  = 8'h80,
  parameter logic [7:0] WR_HI  = 8'hE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               src_addr,
  input  logic [7:0]               dst_addr,
  input  logic [7:0]               len,
  input  logic                     abort,
  mem_copy_master_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [7:0]               xfer_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD      = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] WR      = 2'd3;

  logic [1:0] state;
  logic [7:0] src_r;
  logic [7:0] dst_r;
  logic [7:0] len_r;
  logic [7:0] idx;
  logic [1:0] wait_cnt;
  logic [8:0] src_end;
  logic [8:0] dst_end;
  logic       req_ok;
  logic       last;

  // 9-bit end addresses so a range running past 0xFF is caught, not wrapped
  always_comb begin
    src_end = {1'b0, src_addr} + {1'b0, len} - 9'd1;
    dst_end = {1'b0, dst_addr} + {1'b0, len} - 9'd1;
    req_ok  = (len != 8'd0) && (src_end <= 9'h0FF) &&
              (dst_addr >= WR_LO) && (dst_end <= {1'b0, WR_HI});
  end

  assign last = ((idx + 8'd1) == len_r);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      src_r         <= 8'd0;
      dst_r         <= 8'd0;
      len_r         <= 8'd0;
      idx           <= 8'd0;
      wait_cnt      <= 2'd0;
      bus.mem_addr  <= 8'd0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      xfer_count    <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xfer_count <= 8'd0;
            idx        <= 8'd0;
            if (req_ok) begin
              src_r        <= src_addr;
              dst_r        <= dst_addr;
              len_r        <= len;
              err          <= 1'b0;
              busy         <= 1'b1;
              bus.mem_addr <= src_addr;
              bus.mem_we   <= 1'b0;
              state        <= RD;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        RD: begin
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= 2'(RD_LAT - 1);
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (wait_cnt == 2'd0) begin
            // mem_wdata doubles as the one-byte buffer
            bus.mem_wdata <= bus.mem_rdata;
            bus.mem_addr  <= dst_r + idx;
            bus.mem_we    <= 1'b1;
            state         <= WR;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        WR: begin
          // the write in flight always commits, even when aborting
          idx        <= idx + 8'd1;
          xfer_count <= xfer_count + 8'd1;
          bus.mem_we <= 1'b0;
          if (abort || last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            bus.mem_addr <= src_r + idx + 8'd1;
            state        <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
